// File: rtl/ov7670_sccb_config_seq.sv
// ov7670_sccb_config_seq
// Walks a table of OV7670 register writes held in an external synchronous ROM.
// For each entry it drives the i2c_master command and write-data streams.
// Table entries are {reg_addr, value}:
//   reg_addr 8'hFF ends the table.
//   reg_addr 8'hFE waits value*WAIT_UNIT clocks.
//   Any other reg_addr is an SCCB register write.
// Optional feature macro: SCCB_READBACK_EN. When defined, each written
// register is read back and compared with the written value, and
// mismatch_cnt counts the disagreements.
module ov7670_sccb_config_seq #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         NUM_ENTRIES = 64,
  parameter int         ADDR_W      = 6,
  parameter int         WAIT_UNIT   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        entry_idx,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [6:0]        cmd_address,
  output logic              cmd_start,
  output logic              cmd_read,
  output logic              cmd_write,
  output logic              cmd_write_multiple,
  output logic              cmd_stop,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        data_tdata,
  output logic              data_tvalid,
  input  logic              data_tready,
  output logic              data_tlast,
  input  logic [7:0]        rd_tdata,
  input  logic              rd_tvalid,
  output logic              rd_tready,
  input  logic              i2c_busy,
  input  logic              missed_ack,
  output logic [7:0]        mismatch_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_CMD,
    S_ADDR_BYTE,
    S_VAL_BYTE,
    S_WAIT_IDLE,
    S_DELAY,
`ifdef SCCB_READBACK_EN
    S_RB_CMD_W,
    S_RB_ADDR,
    S_RB_CMD_R,
    S_RB_DATA,
`endif
    S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  idx_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [7:0]  regAddr_q;
  logic [7:0]  value_q;
  logic [31:0] delayCnt_q;
  logic        waitCnt_q;
  logic        cmdValid_q;
  logic        cmdStart_q;
  logic        cmdWm_q;
  logic        cmdStop_q;
  logic        dataValid_q;
  logic        dataLast_q;
  logic [7:0]  dataData_q;
  logic [31:0] delayLoad_d;
  logic        lastEntry;

`ifdef SCCB_READBACK_EN
  logic        cmdRead_q;
  logic        cmdWrite_q;
  logic        rdReady_q;
  logic [7:0]  mismatch_q;

  assign cmd_read     = cmdRead_q;
  assign cmd_write    = cmdWrite_q;
  assign rd_tready    = rdReady_q;
  assign mismatch_cnt = mismatch_q;
`else
  // Read data only matters when readback is compiled in.
  // Stale bytes are still drained by keeping rd_tready high.
  logic unusedRd;
  assign unusedRd     = ^{rd_tdata, rd_tvalid};
  assign cmd_read     = 1'b0;
  assign cmd_write    = 1'b0;
  assign rd_tready    = 1'b1;
  assign mismatch_cnt = 8'd0;
`endif

  assign delayLoad_d = 32'(rom_data[7:0]) * 32'(WAIT_UNIT) - 32'd1;
  assign lastEntry   = (idx_q == 8'(NUM_ENTRIES - 1));

  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign entry_idx          = idx_q;
  assign rom_addr           = idx_q[ADDR_W-1:0];
  assign cmd_address        = DEV_ADDR;
  assign cmd_start          = cmdStart_q;
  assign cmd_write_multiple = cmdWm_q;
  assign cmd_stop           = cmdStop_q;
  assign cmd_valid          = cmdValid_q;
  assign data_tdata         = dataData_q;
  assign data_tvalid        = dataValid_q;
  assign data_tlast         = dataLast_q;

  // Sequencer FSM. Every output is a register, so valid and payload change
  // only on the handshake edge. Finishing an entry either moves on to the
  // next index or, after the final table slot, parks in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      regAddr_q   <= '0;
      value_q     <= '0;
      delayCnt_q  <= '0;
      waitCnt_q   <= 1'b0;
      cmdValid_q  <= 1'b0;
      cmdStart_q  <= 1'b0;
      cmdWm_q     <= 1'b0;
      cmdStop_q   <= 1'b0;
      dataValid_q <= 1'b0;
      dataLast_q  <= 1'b0;
      dataData_q  <= '0;
`ifdef SCCB_READBACK_EN
      cmdRead_q   <= 1'b0;
      cmdWrite_q  <= 1'b0;
      rdReady_q   <= 1'b1;
      mismatch_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_FETCH;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SCCB_READBACK_EN
            rdReady_q  <= 1'b0;
            mismatch_q <= '0;
`endif
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          regAddr_q <= rom_data[15:8];
          value_q   <= rom_data[7:0];
          if (rom_data[15:8] == 8'hFF) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef SCCB_READBACK_EN
            rdReady_q <= 1'b1;
`endif
          end else if (rom_data[15:8] == 8'hFE) begin
            if (rom_data[7:0] == 8'd0) begin
              state_q <= lastEntry ? S_DONE : S_FETCH;
              idx_q   <= lastEntry ? idx_q : idx_q + 8'd1;
              busy_q  <= ~lastEntry;
              done_q  <= lastEntry;
`ifdef SCCB_READBACK_EN
              rdReady_q <= lastEntry;
`endif
            end else begin
              delayCnt_q <= delayLoad_d;
              state_q    <= S_DELAY;
            end
          end else begin
            state_q    <= S_CMD;
            cmdValid_q <= 1'b1;
            cmdStart_q <= 1'b1;
            cmdWm_q    <= 1'b1;
            cmdStop_q  <= 1'b1;
          end
        end
        S_CMD: begin
          if (cmd_ready) begin
            cmdValid_q  <= 1'b0;
            cmdStart_q  <= 1'b0;
            cmdWm_q     <= 1'b0;
            cmdStop_q   <= 1'b0;
            dataValid_q <= 1'b1;
            dataData_q  <= regAddr_q;
            dataLast_q  <= 1'b0;
            state_q     <= S_ADDR_BYTE;
          end
        end
        S_ADDR_BYTE: begin
          if (data_tready) begin
            dataData_q <= value_q;
            dataLast_q <= 1'b1;
            state_q    <= S_VAL_BYTE;
          end
        end
        S_VAL_BYTE: begin
          if (data_tready) begin
            dataValid_q <= 1'b0;
            dataLast_q  <= 1'b0;
            dataData_q  <= '0;
            waitCnt_q   <= 1'b1;
            state_q     <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (waitCnt_q) begin
            waitCnt_q <= 1'b0;
          end else if (!i2c_busy) begin
`ifdef SCCB_READBACK_EN
            state_q    <= S_RB_CMD_W;
            cmdValid_q <= 1'b1;
            cmdStart_q <= 1'b1;
            cmdWrite_q <= 1'b1;
`else
            state_q <= lastEntry ? S_DONE : S_FETCH;
            idx_q   <= lastEntry ? idx_q : idx_q + 8'd1;
            busy_q  <= ~lastEntry;
            done_q  <= lastEntry;
`endif
          end
        end
        S_DELAY: begin
          if (delayCnt_q == 32'd0) begin
            state_q <= lastEntry ? S_DONE : S_FETCH;
            idx_q   <= lastEntry ? idx_q : idx_q + 8'd1;
            busy_q  <= ~lastEntry;
            done_q  <= lastEntry;
`ifdef SCCB_READBACK_EN
            rdReady_q <= lastEntry;
`endif
          end else begin
            delayCnt_q <= delayCnt_q - 32'd1;
          end
        end
`ifdef SCCB_READBACK_EN
        S_RB_CMD_W: begin
          if (cmd_ready) begin
            cmdValid_q  <= 1'b0;
            cmdStart_q  <= 1'b0;
            cmdWrite_q  <= 1'b0;
            dataValid_q <= 1'b1;
            dataData_q  <= regAddr_q;
            dataLast_q  <= 1'b1;
            state_q     <= S_RB_ADDR;
          end
        end
        S_RB_ADDR: begin
          if (data_tready) begin
            dataValid_q <= 1'b0;
            dataLast_q  <= 1'b0;
            dataData_q  <= '0;
            cmdValid_q  <= 1'b1;
            cmdStart_q  <= 1'b1;
            cmdRead_q   <= 1'b1;
            cmdStop_q   <= 1'b1;
            state_q     <= S_RB_CMD_R;
          end
        end
        S_RB_CMD_R: begin
          if (cmd_ready) begin
            cmdValid_q <= 1'b0;
            cmdStart_q <= 1'b0;
            cmdRead_q  <= 1'b0;
            cmdStop_q  <= 1'b0;
            rdReady_q  <= 1'b1;
            state_q    <= S_RB_DATA;
          end
        end
        S_RB_DATA: begin
          if (rd_tvalid) begin
            if (rd_tdata != value_q && mismatch_q != 8'hFF) begin
              mismatch_q <= mismatch_q + 8'd1;
            end
            state_q   <= lastEntry ? S_DONE : S_FETCH;
            idx_q     <= lastEntry ? idx_q : idx_q + 8'd1;
            busy_q    <= ~lastEntry;
            done_q    <= lastEntry;
            rdReady_q <= lastEntry;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      if (busy_q && missed_ack) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ov7670_sccb_config_seq.md
# ov7670_sccb_config_seq

Sequencer that walks a table of OV7670 register writes and drives the i2c_master AXI-stream host interface to program the camera over SCCB. It sits between the camera driver and i2c_master, and owns the i2c command and data channels while a sequence runs. It reads the table from an external synchronous ROM and supports inline delay entries, for example the settle time after a COM7 soft reset. It reports progress to the HCI seven-segment path.

## Interface
Parameters:
- DEV_ADDR, 7'h21, 7-bit SCCB device address, driven on cmd_address.
- NUM_ENTRIES, 64, number of table entries; the sequence never reads past index NUM_ENTRIES-1.
- ADDR_W, 6, ROM address width; must satisfy 2**ADDR_W >= NUM_ENTRIES.
- WAIT_UNIT, 100000, clk cycles per delay unit (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a sequence; honoured only in IDLE or DONE.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  high while in DONE.
- err  out  1  sticky missed-ACK flag; cleared by an accepted start.
- entry_idx  out  8  index of the current entry, zero-extended.
- rom_addr  out  ADDR_W  table read address.
- rom_data  in  16  table entry {reg_addr[15:8], value[7:0]}; valid 1 cycle after rom_addr.
- cmd_address  out  7  always equals DEV_ADDR.
- cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop  out  1 each  i2c_master command fields.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  command accepted.
- data_tdata  out  8  write data.
- data_tvalid  out  1  write data valid.
- data_tready  in  1  write data accepted.
- data_tlast  out  1  last write byte.
- rd_tdata  in  8  read data from i2c_master.
- rd_tvalid  in  1  read data valid.
- rd_tready  out  1  read data ready.
- i2c_busy  in  1  i2c_master busy.
- missed_ack  in  1  i2c_master missed-ACK pulse.
- mismatch_cnt  out  8  readback mismatch count.

## Operation
- Entry decode:
  - reg_addr 8'hFF means end of table; go to DONE.
  - reg_addr 8'hFE means delay of value×WAIT_UNIT cycles. A value of 0 means no delay.
  - Any other reg_addr is a register write.
- States: IDLE → FETCH → DECODE → {CMD → ADDR_BYTE → VAL_BYTE → WAIT_IDLE | DELAY} → FETCH (idx+1) …, ending in DONE.
  - FETCH drives rom_addr = idx.
  - DECODE registers rom_data.
  - CMD asserts cmd_valid with cmd_start=1, cmd_write_multiple=1 and cmd_stop=1, held until cmd_ready.
  - ADDR_BYTE sends data_tdata=reg_addr with data_tlast=0, held until data_tready.
  - VAL_BYTE sends data_tdata=value with data_tlast=1, held until data_tready.
  - WAIT_IDLE waits a minimum of 2 cycles, then until i2c_busy=0.
- After the entry at idx = NUM_ENTRIES-1 completes, go to DONE.
- DONE holds until start, which restarts at idx 0.
- Handshake rules:
  - A transfer occurs on a cycle with valid&ready.
  - Payload and valid never change while valid=1 and ready=0.
  - Valid deasserts in the cycle after the transfer.
- Error handling: missed_ack=1 in any cycle while busy sets err. The sequence continues; a missed ACK does not abort it.
- start while busy is ignored.
- The delay counter is 32 bits and loads value×WAIT_UNIT−1.
- rd_tready is 1 in IDLE and DONE, so stale read bytes are drained.

## Timing
- Reset values:
  - busy=0, done=0, err=0, entry_idx=0, rom_addr=0, mismatch_cnt=0, rd_tready=1.
  - All cmd_* strobes and data_tvalid/data_tlast are 0; data_tdata=0.
  - cmd_address=DEV_ADDR.
  - State is IDLE.
- start accepted at edge N: busy=1 and rom_addr=0 at N+1; DECODE at N+2; cmd_valid at N+3 for a write entry.
- With i2c_master always ready and never busy, a write entry takes 7 cycles FETCH-to-FETCH.
- A delay entry of value v takes v×WAIT_UNIT+2 cycles; v=0 takes 2 cycles.
- done rises in the cycle after the end marker or last entry is decoded. busy falls in the same cycle.
- rst mid-sequence:
  - All outputs return to their reset values immediately (asynchronous reset).
  - An i2c transfer in flight is abandoned; i2c_master is reset by its own rst.
- Simultaneous start and rst: rst wins.

## Configuration
- Macro SCCB_READBACK_EN, compiled in:
  - After each write's WAIT_IDLE, the block issues cmd_write+cmd_start with a single byte reg_addr (tlast=1) and no stop.
  - It then issues cmd_read+cmd_start+cmd_stop.
  - It accepts one rd_tdata byte with rd_tready=1 and compares it to value.
  - On a mismatch, mismatch_cnt increments, saturating at 255.
  - mismatch_cnt is cleared by an accepted start.
- Macro not defined: no readback states; mismatch_cnt is constant 0 and rd_tready is constant 1.

## Test plan
- Table {12_80, FE_01, 11_01, FF_00}, WAIT_UNIT=10, ideal i2c model:
  - Byte streams 12,80 then 11,01, each as a write_multiple with stop.
  - Gap between the two streams is at least 10 cycles.
  - done=1 after the FF entry; entry_idx=3.
- data_tready held low 20 cycles during ADDR_BYTE: data_tdata and data_tvalid stay stable. Transfer completes exactly once when data_tready rises.
- Pulse missed_ack during entry 0 of a 3-entry table: err=1 at end, all 3 entries still sent. Next start clears err.
- rst asserted while in VAL_BYTE: next cycle all outputs are at reset values. A following start restarts from idx 0.
- start pulsed mid-sequence: ignored, no idx reset. After DONE, start reruns the full table.
- SCCB_READBACK_EN with model returning 8'h00 for write 12_80: mismatch_cnt=1. Model returning the matching value: mismatch_cnt=0.
